// File: rtl/csa_resolve_serial.sv
// Serial carry-propagate adder: resolves a carry-save (sum, carry) pair into one binary
// result, CHUNK bits per clock, behind valid/ready handshakes on both sides.
module csa_resolve_serial #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int unsigned PW     = NCHUNK * CHUNK;
    localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned LASTW  = WIDTH - (NCHUNK - 1) * CHUNK;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t          state_q;
    logic [PW-1:0]   a_q;
    logic [PW-1:0]   b_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;

    int unsigned     base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]  csum;
    logic            carry_next;
    logic [WIDTH-1:0] sum_d;

    always_comb begin
        base    = CHUNK * idx_q;
        a_chunk = a_q[base +: CHUNK];
        b_chunk = b_q[base +: CHUNK];
        csum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Operands are zero-padded, so the last chunk's carry sits just above bit WIDTH-1.
        carry_next = (idx_q == LAST_IDX) ? csum[LASTW] : csum[CHUNK];
        sum_d = out_sum;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (base + i < WIDTH) begin
                sum_d[base + i] = csum[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            busy      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        a_q      <= PW'(op_a);
                        b_q      <= PW'(op_b);
                        idx_q    <= '0;
                        carry_q  <= 1'b0;
                        out_sum  <= '0;
                        out_cout <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    out_sum <= sum_d;
                    carry_q <= carry_next;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        out_cout  <= carry_next;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_resolve_serial.sv
// Bench for csa_resolve_serial: two instances (CHUNK=4 and CHUNK=5) checked every cycle against
// an arithmetic transaction model, plus literal directed vectors and tree-legal random streams.
module tb_csa_resolve_serial;

    localparam int W = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst       [2];
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [W-1:0] op_a      [2];
    logic [W-1:0] op_b      [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [W-1:0] out_sum   [2];
    logic         out_cout  [2];
    logic         busy      [2];

    csa_resolve_serial #(.WIDTH(14), .CHUNK(4)) dut0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op_a(op_a[0]), .op_b(op_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(out_sum[0]), .out_cout(out_cout[0]), .busy(busy[0])
    );

    csa_resolve_serial #(.WIDTH(14), .CHUNK(5)) dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op_a(op_a[1]), .op_b(op_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(out_sum[1]), .out_cout(out_cout[1]), .busy(busy[1])
    );

    function automatic int nch(int d);
        return (d == 0) ? 4 : 3;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Transaction model: one pair in flight, result visible NCHUNK edges after accept.
    bit           chk_en = 1'b0;
    bit           pending [2];
    int           age     [2];
    logic [W:0]   exp_r   [2];
    bit           track   [2];
    logic [W-1:0] tree_q  [$];
    logic         ev;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                pending[d] = 1'b0;
                age[d]     = 0;
            end else if (!pending[d]) begin
                if (in_valid[d]) begin
                    pending[d] = 1'b1;
                    age[d]     = 0;
                    exp_r[d]   = {1'b0, op_a[d]} + {1'b0, op_b[d]};
                end
            end else if (age[d] < nch(d)) begin
                age[d]++;
            end else if (out_ready[d]) begin
                pending[d] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                ev = pending[d] && (age[d] >= nch(d));
                chk($sformatf("in_ready%0d", d), in_ready[d], !pending[d]);
                chk($sformatf("busy%0d", d), busy[d], pending[d] && (age[d] < nch(d)));
                chk($sformatf("out_valid%0d", d), out_valid[d], ev);
                if (ev) begin
                    chk($sformatf("out_sum%0d", d), out_sum[d], exp_r[d][W-1:0]);
                    chk($sformatf("out_cout%0d", d), out_cout[d], exp_r[d][W]);
                    if (out_ready[d] && track[d]) begin
                        chk($sformatf("no_dup%0d", d), tree_q.size() > 0, 1'b1);
                        if (tree_q.size() > 0) begin
                            chk($sformatf("tree_sum%0d", d), out_sum[d], tree_q.pop_front());
                            chk($sformatf("tree_cout%0d", d), out_cout[d], 1'b0);
                        end
                    end
                end
            end
        end
    end

    task automatic send(int d, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] tsum);
        int n = 0;
        op_a[d]     = a;
        op_b[d]     = b;
        in_valid[d] = 1'b1;
        @(negedge clk);
        while (!in_ready[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("accept_wait%0d", d), in_ready[d], 1'b1);
        @(posedge clk);
        if (track[d]) tree_q.push_back(tsum);
        #1 in_valid[d] = 1'b0;
    endtask

    task automatic run_lit(int d, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] es, logic ec);
        int n = 0;
        out_ready[d] = 1'b1;
        send(d, a, b, '0);
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid[d] && n < 50);
        chk($sformatf("lit_latency%0d_%0h", d, a), n, nch(d) + 1);
        chk($sformatf("lit_sum%0d_%0h", d, a), out_sum[d], es);
        chk($sformatf("lit_cout%0d_%0h", d, a), out_cout[d], ec);
        @(posedge clk);
        #1;
    endtask

    task automatic stream(int d, int count);
        bit done = 1'b0;
        int n = 0;
        track[d] = 1'b1;
        fork
            begin
                for (int i = 0; i < count; i++) begin
                    logic [14:0] ta, tb, tc, te, s1, c1, s2, c2, ts;
                    ta = 15'($urandom_range(0, 4095));
                    tb = 15'($urandom_range(0, 4095));
                    tc = 15'($urandom_range(0, 4095));
                    te = 15'($urandom_range(0, 4095));
                    if (i == 0) begin
                        ta = 15'd4095; tb = 15'd4095; tc = 15'd4095; te = 15'd4095;
                    end
                    s1 = ta ^ tb ^ tc;
                    c1 = ((ta & tb) | (ta & tc) | (tb & tc)) << 1;
                    s2 = s1 ^ c1 ^ te;
                    c2 = ((s1 & c1) | (s1 & te) | (c1 & te)) << 1;
                    ts = ta + tb + tc + te;
                    send(d, s2[W-1:0], c2[W-1:0], ts[W-1:0]);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready[d] = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready[d] = 1'b1;
        while (tree_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain%0d", d), tree_q.size(), 0);
        @(posedge clk);
        #1 track[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
            op_a[d] = '0; op_b[d] = '0; track[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready[0], 1'b1);
        chk("rst_out_valid", out_valid[0], 1'b0);
        chk("rst_out_sum", out_sum[0], 14'h0000);
        chk("rst_out_cout", out_cout[0], 1'b0);
        chk("rst_busy", busy[0], 1'b0);
        @(posedge clk);
        #1;

        run_lit(0, 14'h0123, 14'h0456, 14'h0579, 1'b0);
        run_lit(0, 14'h0001, 14'h3FFF, 14'h0000, 1'b1);
        run_lit(0, 14'h1FFC, 14'h2000, 14'h3FFC, 1'b0);

        // Back-pressure: result must hold while inputs churn.
        begin
            int n = 0;
            out_ready[0] = 1'b0;
            send(0, 14'h0ABC, 14'h0111, '0);
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid[0] && n < 50);
            chk("bp_valid", out_valid[0], 1'b1);
            repeat (10) begin
                @(posedge clk);
                #1;
                op_a[0] = 14'($urandom);
                op_b[0] = 14'($urandom);
                in_valid[0] = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("bp_sum_hold", out_sum[0], 14'h0BCD);
                chk("bp_in_ready", in_ready[0], 1'b0);
            end
            @(posedge clk);
            #1 in_valid[0] = 1'b0;
            out_ready[0] = 1'b1;
            @(negedge clk);
            chk("bp_valid_before_hs", out_valid[0], 1'b1);
            @(posedge clk);
            #1 out_ready[0] = 1'b0;
            @(negedge clk);
            chk("bp_valid_after_hs", out_valid[0], 1'b0);
            chk("bp_ready_after_hs", in_ready[0], 1'b1);
        end

        // Reset two edges into a run: the pair is discarded.
        out_ready[0] = 1'b1;
        send(0, 14'h0777, 14'h0111, '0);
        @(posedge clk);
        #1 rst[0] = 1'b1;
        @(posedge clk);
        #1 rst[0] = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready[0], 1'b1);
        chk("mid_rst_out_sum", out_sum[0], 14'h0000);
        chk("mid_rst_busy", busy[0], 1'b0);
        repeat (8) begin
            @(negedge clk);
            chk("mid_rst_no_valid", out_valid[0], 1'b0);
        end
        @(posedge clk);
        #1;
        run_lit(0, 14'h0005, 14'h0003, 14'h0008, 1'b0);

        run_lit(1, 14'h0123, 14'h0456, 14'h0579, 1'b0);
        run_lit(1, 14'h0001, 14'h3FFF, 14'h0000, 1'b1);
        run_lit(1, 14'h1FFC, 14'h2000, 14'h3FFC, 1'b0);

        stream(0, 1000);
        stream(1, 1000);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
